// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the data-cache miss controller.
//   - state_e        : miss-handling FSM states
//   - LINE_WORDS     : 32-bit words per 64-byte line
//   - TAG_W          : tag width, addr[31:12]
//   - IDX_*/OFF_*    : set-index and word-offset bit positions in a byte address
//   - WAY0..WAY3     : one-hot way encodings
//   - way_sanitize() : passes a one-hot way through, maps anything else to WAY0
package dcache_pkg;

  localparam int LINE_WORDS = 16;
  localparam int TAG_W      = 20;
  localparam int IDX_LSB    = 6;
  localparam int IDX_MSB    = 11;
  localparam int OFF_LSB    = 2;
  localparam int OFF_MSB    = 5;

  localparam logic [3:0] WAY0 = 4'b0001;
  localparam logic [3:0] WAY1 = 4'b0010;
  localparam logic [3:0] WAY2 = 4'b0100;
  localparam logic [3:0] WAY3 = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_WB_REQ,
    S_WB_DATA,
    S_WB_RESP,
    S_RD_REQ,
    S_RD_DATA,
    S_DONE
  } state_e;

  // A corrupt way vector from the selector must never enable more than one
  // data-RAM bank, so anything that is not exactly one-hot falls back to way 0.
  function automatic logic [3:0] way_sanitize(input logic [3:0] w);
    logic [3:0] r;
    case (w)
      WAY0, WAY1, WAY2, WAY3: r = w;
      default:                r = WAY0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dcache_miss_ctrl_beat_cnt.sv
// line_beat_cnt: 4-bit start-loadable wrapping beat counter for line bursts.
//   clk, rst : clock, synchronous active-high reset
//   load     : load idx with start and clear the beat count (priority over inc)
//   start    : first word index of the burst
//   inc      : one beat transferred this cycle
//   idx      : current word index, wraps modulo 16
//   last     : current beat is the final beat of the line (BEATS-th)
module line_beat_cnt #(
  parameter int BEATS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] start,
  input  logic       inc,
  output logic [3:0] idx,
  output logic       last
);

  logic [3:0] idx_q, idx_d;
  logic [3:0] n_q, n_d;

  always_comb begin
    idx_d = idx_q;
    n_d   = n_q;
    if (load) begin
      idx_d = start;
      n_d   = 4'd0;
    end else if (inc) begin
      idx_d = idx_q + 4'd1;
      n_d   = n_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 4'd0;
      n_q   <= 4'd0;
    end else begin
      idx_q <= idx_d;
      n_q   <= n_d;
    end
  end

  assign idx  = idx_q;
  assign last = (n_q == 4'(BEATS - 1));

endmodule

// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: miss handler for the 4-way, 64-set, 64-byte-line D-cache.
// Latches a miss, picks the victim, writes it back if dirty, refills the line
// into the data RAM and pulses the LRU update for the refilled way.
//   miss_req/miss_addr/miss_ack          : pipeline miss handshake
//   victim_way/dirty/tag, lru_addr       : way selector lookup
//   lru_en/lru_visit                     : LRU update pulse
//   line_ridx/line_rdata                 : data-RAM read port (writeback)
//   fill_we/fill_widx/fill_wdata         : data-RAM write port (refill)
//   wr_*                                 : writeback burst to the memory bus
//   rd_*                                 : refill burst from the memory bus
//   crit_valid                           : early-restart pulse on first refill beat
// Build option: DCACHE_CRIT_WORD_EN enables critical-word-first refill.
module dcache_miss_ctrl
  import dcache_pkg::*;
#(
  parameter int LINE_WORDS = 16,
  parameter int TAG_W      = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss_req,
  input  logic [31:0]      miss_addr,
  output logic             miss_ack,
  input  logic [3:0]       victim_way,
  input  logic             victim_dirty,
  input  logic [TAG_W-1:0] victim_tag,
  output logic [31:0]      lru_addr,
  output logic             lru_en,
  output logic [3:0]       lru_visit,
  output logic [3:0]       line_ridx,
  input  logic [31:0]      line_rdata,
  output logic [3:0]       fill_we,
  output logic [3:0]       fill_widx,
  output logic [31:0]      fill_wdata,
  output logic             wr_req,
  output logic [31:0]      wr_addr,
  input  logic             wr_gnt,
  output logic             wr_valid,
  output logic [31:0]      wr_data,
  output logic             wr_last,
  input  logic             wr_ready,
  input  logic             wr_done,
  output logic             rd_req,
  output logic [31:0]      rd_addr,
  input  logic             rd_gnt,
  input  logic             rd_valid,
  input  logic [31:0]      rd_data,
  output logic             crit_valid
);

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         victim_q, victim_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic       cnt_load;
  logic       wb_inc, rd_inc;
  logic [3:0] wb_idx, rd_idx, rd_start;
  logic       wb_last, rd_last;

`ifdef DCACHE_CRIT_WORD_EN
  assign rd_start = addr_q[OFF_MSB:OFF_LSB];
`else
  assign rd_start = 4'd0;
`endif

  // Both counters are armed in SEL, when the miss address is already latched.
  assign cnt_load = (state_q == S_SEL);

  line_beat_cnt #(.BEATS(LINE_WORDS)) u_wb_cnt (
    .clk(clk), .rst(rst), .load(cnt_load), .start(4'd0),
    .inc(wb_inc), .idx(wb_idx), .last(wb_last)
  );

  line_beat_cnt #(.BEATS(LINE_WORDS)) u_rd_cnt (
    .clk(clk), .rst(rst), .load(cnt_load), .start(rd_start),
    .inc(rd_inc), .idx(rd_idx), .last(rd_last)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    victim_d   = victim_q;
    tag_d      = tag_q;
    miss_ack   = 1'b0;
    lru_en     = 1'b0;
    line_ridx  = wb_idx;
    fill_we    = 4'd0;
    fill_widx  = 4'd0;
    fill_wdata = 32'd0;
    wr_req     = 1'b0;
    wr_addr    = 32'd0;
    wr_valid   = 1'b0;
    wr_data    = 32'd0;
    wr_last    = 1'b0;
    rd_req     = 1'b0;
    rd_addr    = 32'd0;
    crit_valid = 1'b0;
    wb_inc     = 1'b0;
    rd_inc     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          addr_d  = miss_addr;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        victim_d = way_sanitize(victim_way);
        tag_d    = victim_tag;
        state_d  = victim_dirty ? S_WB_REQ : S_RD_REQ;
      end
      S_WB_REQ: begin
        // line_ridx is 0 here, so word 0 is on line_rdata at WB_DATA entry.
        wr_req  = 1'b1;
        wr_addr = 32'({tag_q, addr_q[IDX_MSB:IDX_LSB], 6'b0});
        if (wr_gnt) state_d = S_WB_DATA;
      end
      S_WB_DATA: begin
        wr_valid = 1'b1;
        wr_data  = line_rdata;
        wr_last  = wb_last;
        // Read one word ahead only on a handshake so a stall keeps data stable.
        if (wr_ready) begin
          wb_inc    = 1'b1;
          line_ridx = wb_idx + 4'd1;
          if (wb_last) state_d = S_WB_RESP;
        end
      end
      S_WB_RESP: begin
        if (wr_done) state_d = S_RD_REQ;
      end
      S_RD_REQ: begin
        rd_req = 1'b1;
`ifdef DCACHE_CRIT_WORD_EN
        rd_addr = {addr_q[31:OFF_LSB], 2'b00};
`else
        rd_addr = {addr_q[31:IDX_LSB], 6'b0};
`endif
        if (rd_gnt) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (rd_valid) begin
          fill_we    = victim_q;
          fill_widx  = rd_idx;
          fill_wdata = rd_data;
          rd_inc     = 1'b1;
`ifdef DCACHE_CRIT_WORD_EN
          // The burst starts at the missed word, so it is the first beat only.
          crit_valid = (rd_idx == addr_q[OFF_MSB:OFF_LSB]);
`endif
          if (rd_last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        miss_ack = 1'b1;
        lru_en   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'd0;
      victim_q <= 4'd0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      victim_q <= victim_d;
      tag_q    <= tag_d;
    end
  end

  assign lru_addr  = addr_q;
  assign lru_visit = victim_q;

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl: directed self-checking bench for dcache_miss_ctrl.
// A per-cycle bus/RAM model drives grants, beats and the data-RAM read data;
// each test task runs one scenario and compares against hand-derived values.
module tb_dcache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic        miss_ack;
  logic [3:0]  victim_way;
  logic        victim_dirty;
  logic [19:0] victim_tag;
  logic [31:0] lru_addr;
  logic        lru_en;
  logic [3:0]  lru_visit;
  logic [3:0]  line_ridx;
  logic [31:0] line_rdata;
  logic [3:0]  fill_we;
  logic [3:0]  fill_widx;
  logic [31:0] fill_wdata;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic        wr_gnt;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_last;
  logic        wr_ready;
  logic        wr_done;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        crit_valid;

  always #5 clk = ~clk;

  dcache_miss_ctrl dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack),
    .victim_way(victim_way), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .lru_addr(lru_addr), .lru_en(lru_en), .lru_visit(lru_visit),
    .line_ridx(line_ridx), .line_rdata(line_rdata),
    .fill_we(fill_we), .fill_widx(fill_widx), .fill_wdata(fill_wdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_gnt(wr_gnt),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .crit_valid(crit_valid)
  );

  int checks = 0;
  int errors = 0;

  // Per-run observations gathered by run_miss.
  logic [31:0] seen_rd_addr, seen_wr_addr;
  logic [3:0]  fill_we_seen, visit_seen;
  logic [3:0]  widx [16];
  int nfill, nhs, stalls, ack_cycle, lru_cyc, rd_first_cyc;
  int fill_we_bad, wdata_bad, wrdata_bad, ridx_bad, last_bad, rdreq_early;
  int crit_count, crit_beat;

  function automatic bit any_out();
    return |{miss_ack, lru_en, lru_visit, lru_addr, line_ridx, fill_we, fill_widx,
             fill_wdata, wr_req, wr_addr, wr_valid, wr_data, wr_last, rd_req,
             rd_addr, crit_valid};
  endfunction

  // Runs one miss with a zero-wait (or randomly stalled) bus. rst_beat >= 0
  // asserts rst right after that refill beat and returns after the reset edge.
  task automatic run_miss(input logic [31:0] addr, input logic [3:0] way,
                          input logic dirty, input logic [19:0] tag,
                          input bit stall, input int rst_beat);
    int wb_wait;
    bit wb_seen, done_issued, rst_hit;
    logic [3:0] r;
    nfill = 0; nhs = 0; stalls = 0; ack_cycle = -1; lru_cyc = -1; rd_first_cyc = -1;
    fill_we_bad = 0; wdata_bad = 0; wrdata_bad = 0; ridx_bad = 0; last_bad = 0;
    rdreq_early = 0; crit_count = 0; crit_beat = -1;
    seen_rd_addr = 'x; seen_wr_addr = 'x; fill_we_seen = 4'd0; visit_seen = 'x;
    for (int i = 0; i < 16; i++) widx[i] = 4'hx;
    wb_wait = 0; wb_seen = 0; done_issued = 0; rst_hit = 0;
    @(negedge clk);
    miss_req = 1'b1; miss_addr = addr;
    victim_way = way; victim_dirty = dirty; victim_tag = tag;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (cyc > 1) begin
        @(negedge clk);
        miss_req = 1'b0;
      end
      rd_gnt   = rd_req;
      wr_gnt   = wr_req;
      wr_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_valid = 1'b1;
      rd_data  = 32'hF111_0000 | 32'(nfill);
      wr_done  = (cyc == 2);
      if (wb_seen) begin
        if (wb_wait == 2) wr_done = 1'b1;
        wb_wait++;
      end
      #1;
      if (rd_req && rd_first_cyc < 0) begin
        rd_first_cyc = cyc;
        seen_rd_addr = rd_addr;
      end
      if (rd_req && dirty && !done_issued) rdreq_early++;
      if (wr_req) seen_wr_addr = wr_addr;
      if (wr_valid) begin
        if (wr_data !== (32'hCAFE_0000 | 32'(nhs))) wrdata_bad++;
        if (line_ridx !== 4'(wr_ready ? nhs + 1 : nhs)) ridx_bad++;
        if (wr_ready) begin
          if (wr_last !== (nhs == 15)) last_bad++;
          nhs++;
          if (nhs == 16) wb_seen = 1;
        end else stalls++;
      end
      if (wb_seen && wr_done) done_issued = 1;
      if (crit_valid) begin
        crit_count++;
        if (fill_we != 4'd0) crit_beat = nfill;
      end
      if (fill_we != 4'd0) begin
        if (nfill > 0 && fill_we !== fill_we_seen) fill_we_bad++;
        fill_we_seen = fill_we;
        if (nfill < 16) widx[nfill] = fill_widx;
        if (fill_wdata !== rd_data) wdata_bad++;
        nfill++;
        if (nfill == rst_beat + 1) begin
          rst = 1'b1;
          rst_hit = 1;
        end
      end
      if (lru_en) begin
        lru_cyc = cyc;
        visit_seen = lru_visit;
      end
      if (miss_ack) ack_cycle = cyc;
      r = line_ridx;
      @(posedge clk);
      #1;
      line_rdata = 32'hCAFE_0000 | 32'(r);
      if (rst_hit || ack_cycle > 0) break;
    end
    rd_gnt = 1'b0; wr_gnt = 1'b0; rd_valid = 1'b0; wr_done = 1'b0; wr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (any_out() !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero outputs want all 0");
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (any_out() !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs got nonzero outputs want all 0");
    end
  endtask

  task automatic test_clean_miss();
    int bad;
    logic [31:0] exp_rd;
    logic [3:0] s;
`ifdef DCACHE_CRIT_WORD_EN
    exp_rd = 32'h0000_1A44; s = 4'd1;
`else
    exp_rd = 32'h0000_1A40; s = 4'd0;
`endif
    run_miss(32'h0000_1A44, 4'b0100, 1'b0, 20'h0, 1'b0, -1);
    checks++;
    if (seen_rd_addr !== exp_rd) begin
      errors++; $display("FAIL clean_rd_addr got %h want %h", seen_rd_addr, exp_rd);
    end
    checks++;
    if (rd_first_cyc !== 3) begin
      errors++; $display("FAIL clean_rd_req_cycle got %0d want 3", rd_first_cyc);
    end
    checks++;
    if (nfill !== 16) begin
      errors++; $display("FAIL clean_fill_beats got %0d want 16", nfill);
    end
    checks++;
    if (fill_we_seen !== 4'b0100 || fill_we_bad !== 0) begin
      errors++; $display("FAIL clean_fill_we got %b (bad %0d) want 0100", fill_we_seen, fill_we_bad);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (widx[i] !== 4'(s + 4'(i))) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL clean_fill_widx got %0d wrong indices want 0", bad);
    end
    checks++;
    if (wdata_bad !== 0) begin
      errors++; $display("FAIL clean_fill_wdata got %0d wrong words want 0", wdata_bad);
    end
    checks++;
    if (ack_cycle !== 20 || lru_cyc !== 20) begin
      errors++; $display("FAIL clean_ack_latency got ack %0d lru %0d want 20", ack_cycle, lru_cyc);
    end
    checks++;
    if (visit_seen !== 4'b0100) begin
      errors++; $display("FAIL clean_lru_visit got %b want 0100", visit_seen);
    end
    @(negedge clk);
    checks++;
    if ({miss_ack, lru_en} !== 2'b00) begin
      errors++; $display("FAIL clean_ack_pulse got %b want 00", {miss_ack, lru_en});
    end
  endtask

  task automatic test_dirty_miss();
    run_miss(32'h1234_5A48, 4'b0010, 1'b1, 20'hABCDE, 1'b0, -1);
    checks++;
    if (seen_wr_addr !== 32'hABCD_EA40) begin
      errors++; $display("FAIL dirty_wr_addr got %h want abcdea40", seen_wr_addr);
    end
    checks++;
    if (nhs !== 16 || wrdata_bad !== 0) begin
      errors++; $display("FAIL dirty_wr_beats got %0d beats %0d bad want 16/0", nhs, wrdata_bad);
    end
    checks++;
    if (last_bad !== 0) begin
      errors++; $display("FAIL dirty_wr_last got %0d misplaced want 0", last_bad);
    end
    checks++;
    if (rdreq_early !== 0 || rd_first_cyc !== 23) begin
      errors++; $display("FAIL dirty_rd_after_done got early %0d first %0d want 0/23", rdreq_early, rd_first_cyc);
    end
    checks++;
    if (ack_cycle !== 40) begin
      errors++; $display("FAIL dirty_ack_latency got %0d want 40", ack_cycle);
    end
  endtask

  task automatic test_wr_stall();
    run_miss(32'h0000_0F80, 4'b1000, 1'b1, 20'h13579, 1'b1, -1);
    checks++;
    if (nhs !== 16) begin
      errors++; $display("FAIL stall_handshakes got %0d want 16", nhs);
    end
    checks++;
    if (wrdata_bad !== 0 || ridx_bad !== 0) begin
      errors++; $display("FAIL stall_hold got data %0d ridx %0d bad want 0/0", wrdata_bad, ridx_bad);
    end
    checks++;
    if ((stalls > 0) !== 1'b1 || ack_cycle <= 0) begin
      errors++; $display("FAIL stall_progress got stalls %0d ack %0d want >0/>0", stalls, ack_cycle);
    end
  endtask

  task automatic test_crit_word();
    int bad;
    logic [31:0] exp_rd;
    logic [3:0] s;
    int exp_cnt, exp_beat;
`ifdef DCACHE_CRIT_WORD_EN
    exp_rd = 32'h0000_2024; s = 4'd9; exp_cnt = 1; exp_beat = 0;
`else
    exp_rd = 32'h0000_2000; s = 4'd0; exp_cnt = 0; exp_beat = -1;
`endif
    run_miss(32'h0000_2024, 4'b0001, 1'b0, 20'h0, 1'b0, -1);
    checks++;
    if (seen_rd_addr !== exp_rd) begin
      errors++; $display("FAIL crit_rd_addr got %h want %h", seen_rd_addr, exp_rd);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (widx[i] !== 4'(s + 4'(i))) bad++;
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL crit_fill_order got %0d wrong indices want 0", bad);
    end
    checks++;
    if (crit_count !== exp_cnt || crit_beat !== exp_beat) begin
      errors++; $display("FAIL crit_valid got %0d pulses at %0d want %0d at %0d", crit_count, crit_beat, exp_cnt, exp_beat);
    end
  endtask

  task automatic test_mid_reset();
    run_miss(32'h0000_1A44, 4'b0100, 1'b0, 20'h0, 1'b0, 7);
    @(negedge clk);
    checks++;
    if (nfill !== 8 || any_out() !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got beats %0d nonzero %0b want 8/0", nfill, any_out());
    end
    rst = 1'b0;
    run_miss(32'h0000_0C00, 4'b0010, 1'b0, 20'h0, 1'b0, -1);
    checks++;
    if (ack_cycle !== 20 || nfill !== 16 || fill_we_seen !== 4'b0010) begin
      errors++; $display("FAIL midrst_recover got ack %0d beats %0d we %b want 20/16/0010", ack_cycle, nfill, fill_we_seen);
    end
  endtask

  task automatic test_bad_way();
    run_miss(32'h0000_3000, 4'b0110, 1'b0, 20'h0, 1'b0, -1);
    checks++;
    if (fill_we_seen !== 4'b0001 || fill_we_bad !== 0) begin
      errors++; $display("FAIL badway_fill_we got %b want 0001", fill_we_seen);
    end
    checks++;
    if (visit_seen !== 4'b0001) begin
      errors++; $display("FAIL badway_lru_visit got %b want 0001", visit_seen);
    end
  endtask

  initial begin
    rst = 1'b1; miss_req = 1'b0; miss_addr = 32'd0;
    victim_way = 4'd0; victim_dirty = 1'b0; victim_tag = 20'd0;
    line_rdata = 32'd0; wr_gnt = 1'b0; wr_ready = 1'b0; wr_done = 1'b0;
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = 32'd0;
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_wr_stall();
    test_crit_word();
    test_mid_reset();
    test_bad_way();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
